// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared encodings for the run controller.
// Holds the STATE and CMD encodings, the width of the RETIRED counter and
// a small helper that turns a requested step count into the loaded count.
package run_ctrl_pkg;

    // Width of the retired-instruction counter
    localparam int RETIRED_W = 16;

    // Saturation value of the retired-instruction counter
    localparam logic [RETIRED_W-1:0] RETIRED_MAX = {RETIRED_W{1'b1}};

    // Controller state encoding, also driven out on STATE
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    // Command encoding on CMD
    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_STOP = 2'b11
    } cmd_e;

    // A requested step count of zero still executes one instruction
    function automatic logic [7:0] step_load(input logic [7:0] count);
        logic [7:0] result;
        if (count == 8'd0) begin
            result = 8'd1;
        end else begin
            result = count;
        end
        return result;
    endfunction

endpackage

// File: rtl/retire_counter.sv
// retire_counter: saturating count of retired instructions.
// Clears on synchronous active-high reset, increments on inc and sticks at
// the all-ones value instead of wrapping.
module retire_counter
    import run_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [RETIRED_W-1:0] count
);

    logic [RETIRED_W-1:0] count_r;

    // Saturating increment; reset has priority over counting
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {RETIRED_W{1'b0}};
        end else if (inc && (count_r != RETIRED_MAX)) begin
            count_r <= count_r + {{(RETIRED_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run / step / halt controller for a simple CPU.
// Gates the CPU through the active-low enable EN_L, which is decoded from the
// state register only. Commands: RUN, STEP (count, 0 means 1), STOP.
// NextPC == PC while executing is a halt, left only through RESET.
// Optional feature macro: RUN_CTRL_BREAKPOINT_EN compiles in the breakpoint
// (stop before the instruction at BP_ADDR while running, sticky BP_HIT).
// Without it BP_ADDR/BP_ARM are ignored and BP_HIT is tied low.
module run_ctrl
    import run_ctrl_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CMD_VALID,
    input  logic [1:0]           CMD,
    output logic                 CMD_READY,
    input  logic [7:0]           STEP_COUNT,
    input  logic [7:0]           PC,
    input  logic [7:0]           NextPC,
    input  logic [7:0]           BP_ADDR,
    input  logic                 BP_ARM,
    output logic                 EN_L,
    output logic [1:0]           STATE,
    output logic                 DONE,
    output logic                 BP_HIT,
    output logic                 CMD_ERR,
    output logic [RETIRED_W-1:0] RETIRED
);

    state_e     state_r;
    logic [7:0] remaining_r;
    logic       done_r;
    logic       cmd_err_r;

    logic       cmd_acc_s;
    logic       is_run_s;
    logic       is_step_s;
    logic       is_stop_s;
    logic       running_s;
    logic       halt_s;
    logic       bp_stop_s;
    logic       retire_s;

    // Commands are taken every cycle except while reset is held
    assign CMD_READY = ~RESET;
    assign cmd_acc_s = CMD_VALID & CMD_READY;
    assign is_run_s  = cmd_acc_s && (CMD == CMD_RUN);
    assign is_step_s = cmd_acc_s && (CMD == CMD_STEP);
    assign is_stop_s = cmd_acc_s && (CMD == CMD_STOP);

    // The CPU is enabled in RUN and STEP only, decoded purely from state_r
    assign running_s = (state_r == ST_RUN) || (state_r == ST_STEP);
    assign EN_L      = ~running_s;

    // A CPU that does not advance its PC has executed a halt
    assign halt_s    = (NextPC == PC);

    // An instruction retires when the CPU is enabled and the PC moves;
    // 8'hFF -> 8'h00 is simply a PC change like any other
    assign retire_s  = running_s && (NextPC != PC);

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic bp_hit_r;

    // Breakpoint matches on the upcoming PC so the CPU stops before it
    assign bp_stop_s = (state_r == ST_RUN) && BP_ARM && (NextPC == BP_ADDR);

    // Sticky breakpoint flag: set when the breakpoint actually ends the run
    // (halt and STOP win over it), cleared by a new RUN or STEP command
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bp_hit_r <= 1'b0;
        end else if (bp_stop_s && !halt_s && !is_stop_s) begin
            bp_hit_r <= 1'b1;
        end else if (is_run_s || is_step_s) begin
            bp_hit_r <= 1'b0;
        end else begin
            bp_hit_r <= bp_hit_r;
        end
    end

    assign BP_HIT = bp_hit_r;
`else
    logic unused_bp_s;

    assign unused_bp_s = ^{BP_ADDR, BP_ARM};
    assign bp_stop_s   = 1'b0;
    assign BP_HIT      = 1'b0;
`endif

    // Controller FSM with registered DONE / CMD_ERR pulses and step budget
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            remaining_r <= 8'd0;
            done_r      <= 1'b0;
            cmd_err_r   <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            cmd_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (is_run_s) begin
                        state_r <= ST_RUN;
                    end else if (is_step_s) begin
                        state_r     <= ST_STEP;
                        remaining_r <= step_load(STEP_COUNT);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN, ST_STEP: begin
                    // A second RUN/STEP while executing is dropped
                    if (is_run_s || is_step_s) begin
                        cmd_err_r <= 1'b1;
                    end else begin
                        cmd_err_r <= 1'b0;
                    end
                    // Priority: halt > STOP > breakpoint > step expiry
                    if (halt_s) begin
                        state_r     <= ST_HALT;
                        remaining_r <= 8'd0;
                    end else if (is_stop_s) begin
                        state_r     <= ST_IDLE;
                        remaining_r <= 8'd0;
                        done_r      <= 1'b1;
                    end else if (bp_stop_s) begin
                        state_r     <= ST_IDLE;
                        remaining_r <= 8'd0;
                        done_r      <= 1'b1;
                    end else if ((state_r == ST_STEP) && (remaining_r <= 8'd1)) begin
                        state_r     <= ST_IDLE;
                        remaining_r <= 8'd0;
                        done_r      <= 1'b1;
                    end else if (state_r == ST_STEP) begin
                        remaining_r <= remaining_r - 8'd1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_HALT: begin
                    // Only reset leaves HALT; any real command is an error
                    state_r <= ST_HALT;
                    if (cmd_acc_s && (CMD != CMD_NOP)) begin
                        cmd_err_r <= 1'b1;
                    end else begin
                        cmd_err_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    remaining_r <= 8'd0;
                end
            endcase
        end
    end

    assign STATE   = state_r;
    assign DONE    = done_r;
    assign CMD_ERR = cmd_err_r;

    retire_counter u_retire (
        .clk   (CLK),
        .reset (RESET),
        .inc   (retire_s),
        .count (RETIRED)
    );

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl.
// A tiny CPU model in the tick task moves PC to NextPC on every clock edge
// where EN_L was low, and NextPC = PC + stride (stride 0 = halt).
module tb_run_ctrl;

    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_RUN  = 2'b01;
    localparam logic [1:0] C_STEP = 2'b10;
    localparam logic [1:0] C_STOP = 2'b11;

    logic        CLK;
    logic        RESET;
    logic        CMD_VALID;
    logic [1:0]  CMD;
    logic        CMD_READY;
    logic [7:0]  STEP_COUNT;
    logic [7:0]  PC;
    logic [7:0]  NextPC;
    logic [7:0]  BP_ADDR;
    logic        BP_ARM;
    logic        EN_L;
    logic [1:0]  STATE;
    logic        DONE;
    logic        BP_HIT;
    logic        CMD_ERR;
    logic [15:0] RETIRED;

    int checks;
    int errors;
    int en_low_cnt;
    int done_cnt;
    int err_cnt;
    int stride;

    run_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CMD_VALID  (CMD_VALID),
        .CMD        (CMD),
        .CMD_READY  (CMD_READY),
        .STEP_COUNT (STEP_COUNT),
        .PC         (PC),
        .NextPC     (NextPC),
        .BP_ADDR    (BP_ADDR),
        .BP_ARM     (BP_ARM),
        .EN_L       (EN_L),
        .STATE      (STATE),
        .DONE       (DONE),
        .BP_HIT     (BP_HIT),
        .CMD_ERR    (CMD_ERR),
        .RETIRED    (RETIRED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: CPU model advances if enabled, pulses are counted after the edge
    task automatic tick();
        logic en_seen;
        en_seen = EN_L;
        @(posedge CLK);
        #1;
        if (en_seen === 1'b0) begin
            PC = NextPC;
            en_low_cnt++;
        end
        NextPC = PC + stride[7:0];
        if (DONE === 1'b1) done_cnt++;
        if (CMD_ERR === 1'b1) err_cnt++;
    endtask

    task automatic send(input logic [1:0] c);
        CMD_VALID = 1'b1;
        CMD = c;
        tick();
        CMD_VALID = 1'b0;
        CMD = C_NOP;
    endtask

    task automatic set_stride(input int s);
        stride = s;
        NextPC = PC + s[7:0];
    endtask

    task automatic clear_counts();
        en_low_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        CMD_VALID = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (STATE == 2'b00) break;
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; stride = 0;
        clear_counts();
        RESET = 1'b0; CMD_VALID = 1'b0; CMD = C_NOP; STEP_COUNT = 8'd0;
        PC = 8'd0; NextPC = 8'd0; BP_ADDR = 8'd0; BP_ARM = 1'b0;

        // Reset state
        RESET = 1'b1;
        #1;
        check_value("ready_in_reset", 32'(CMD_READY), 32'd0);
        tick();
        RESET = 1'b0;
        check_value("rst_state", 32'(STATE), 32'd0);
        check_value("rst_en_l", 32'(EN_L), 32'd1);
        check_value("rst_done", 32'(DONE), 32'd0);
        check_value("rst_bp_hit", 32'(BP_HIT), 32'd0);
        check_value("rst_cmd_err", 32'(CMD_ERR), 32'd0);
        check_value("rst_retired", 32'(RETIRED), 32'd0);

        // STEP 3 with PC advancing by 2
        PC = 8'd0; set_stride(2); STEP_COUNT = 8'd3;
        tick();
        check_value("ready_idle", 32'(CMD_READY), 32'd1);
        clear_counts();
        send(C_STEP);
        check_value("step3_state", 32'(STATE), 32'd2);
        wait_idle();
        check_value("step3_idle", 32'(STATE), 32'd0);
        check_value("step3_en_cycles", 32'(en_low_cnt), 32'd3);
        check_value("step3_done", 32'(done_cnt), 32'd1);
        check_value("step3_retired", 32'(RETIRED), 32'd3);
        check_value("step3_pc", 32'(PC), 32'h06);
        tick(); tick();
        check_value("step3_no_extra", 32'(en_low_cnt), 32'd3);

        // STEP with count 0 executes exactly one instruction
        clear_counts();
        STEP_COUNT = 8'd0;
        send(C_STEP);
        wait_idle();
        tick(); tick();
        check_value("step0_en_cycles", 32'(en_low_cnt), 32'd1);
        check_value("step0_done", 32'(done_cnt), 32'd1);
        check_value("step0_retired", 32'(RETIRED), 32'd4);
        check_value("step0_pc", 32'(PC), 32'h08);

        // Breakpoint at 8'h08 while running 0,2,4,6
        do_reset();
        PC = 8'd0; set_stride(2); BP_ADDR = 8'h08; BP_ARM = 1'b1;
        clear_counts();
        send(C_RUN);
        repeat (4) tick();
`ifdef RUN_CTRL_BREAKPOINT_EN
        check_value("bp_state", 32'(STATE), 32'd0);
        check_value("bp_pc", 32'(PC), 32'h08);
        check_value("bp_en_l", 32'(EN_L), 32'd1);
        check_value("bp_hit", 32'(BP_HIT), 32'd1);
        check_value("bp_retired", 32'(RETIRED), 32'd4);
        check_value("bp_done", 32'(done_cnt), 32'd1);
        BP_ARM = 1'b0;
        send(C_RUN);
        check_value("bp_clear_on_run", 32'(BP_HIT), 32'd0);
        check_value("bp_rerun_state", 32'(STATE), 32'd1);
        send(C_STOP);
        check_value("bp_stop_state", 32'(STATE), 32'd0);
`else
        check_value("nobp_state", 32'(STATE), 32'd1);
        check_value("nobp_pc", 32'(PC), 32'h08);
        check_value("nobp_hit", 32'(BP_HIT), 32'd0);
        check_value("nobp_retired", 32'(RETIRED), 32'd4);
        send(C_STOP);
        check_value("nobp_stop_state", 32'(STATE), 32'd0);
        check_value("nobp_stop_retired", 32'(RETIRED), 32'd5);
        check_value("nobp_done", 32'(done_cnt), 32'd1);
`endif

        // Halt at PC 8'h0A, commands in HALT are errors, reset leaves HALT
        do_reset();
        BP_ARM = 1'b0; PC = 8'd0; set_stride(2);
        clear_counts();
        send(C_RUN);
        for (int i = 0; i < 20; i++) begin
            if (PC == 8'h0A) break;
            tick();
        end
        set_stride(0);
        tick();
        check_value("halt_state", 32'(STATE), 32'd3);
        check_value("halt_en_l", 32'(EN_L), 32'd1);
        check_value("halt_retired", 32'(RETIRED), 32'd5);
        check_value("halt_no_done", 32'(done_cnt), 32'd0);
        send(C_RUN);
        check_value("halt_cmd_err", 32'(CMD_ERR), 32'd1);
        check_value("halt_still", 32'(STATE), 32'd3);
        tick();
        check_value("halt_err_pulse", 32'(CMD_ERR), 32'd0);
        do_reset();
        check_value("halt_reset_idle", 32'(STATE), 32'd0);

        // Dropped RUN while running, then STOP and halt in the same cycle
        PC = 8'h20; set_stride(1);
        clear_counts();
        send(C_RUN);
        send(C_RUN);
        check_value("run_drop_err", 32'(CMD_ERR), 32'd1);
        check_value("run_drop_state", 32'(STATE), 32'd1);
        tick();
        set_stride(0);
        send(C_STOP);
        check_value("stop_halt_state", 32'(STATE), 32'd3);
        check_value("stop_halt_no_done", 32'(done_cnt), 32'd0);
        check_value("stop_halt_en_l", 32'(EN_L), 32'd1);

        // RESET during STEP with 5 instructions still to go
        do_reset();
        PC = 8'd0; set_stride(1); STEP_COUNT = 8'd8;
        clear_counts();
        send(C_STEP);
        repeat (3) tick();
        check_value("mid_step_state", 32'(STATE), 32'd2);
        check_value("mid_step_retired", 32'(RETIRED), 32'd3);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_value("abort_state", 32'(STATE), 32'd0);
        check_value("abort_retired", 32'(RETIRED), 32'd0);
        check_value("abort_en_l", 32'(EN_L), 32'd1);
        repeat (3) tick();
        check_value("abort_no_done", 32'(done_cnt), 32'd0);
        check_value("abort_en_cycles", 32'(en_low_cnt), 32'd4);

        // Saturation of RETIRED, PC wrapping through 8'hFF
        do_reset();
        PC = 8'd0; set_stride(1);
        send(C_RUN);
        repeat (65534) tick();
        check_value("sat_fffe", 32'(RETIRED), 32'h0000FFFE);
        check_value("sat_pc_fe", 32'(PC), 32'h000000FE);
        tick();
        check_value("sat_ffff", 32'(RETIRED), 32'h0000FFFF);
        repeat (3) tick();
        check_value("sat_hold", 32'(RETIRED), 32'h0000FFFF);
        check_value("sat_pc_wrap", 32'(PC), 32'h00000002);
        send(C_STOP);
        check_value("sat_stop_state", 32'(STATE), 32'd0);
        check_value("sat_stop_retired", 32'(RETIRED), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning), clock and reset first:
REQ-002 CLK  in  1  sole clock; all state updates on posedge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 CMD_VALID  in  1  command strobe.
REQ-005 CMD  in  2  command: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
REQ-006 CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
REQ-007 STEP_COUNT  in  8  instructions to execute for STEP; 0 treated as 1.
REQ-008 PC  in  8  cpu current PC.
REQ-009 NextPC  in  8  cpu next PC.
REQ-010 BP_ADDR  in  8  breakpoint address.
REQ-011 BP_ARM  in  1  breakpoint enable.
REQ-012 EN_L  out  1  cpu enable, active-low; 0 = cpu executes one instruction at the next posedge.
REQ-013 STATE  out  2  current state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT.
REQ-014 DONE  out  1  one-cycle pulse when RUN/STEP ends in IDLE.
REQ-015 BP_HIT  out  1  sticky; set on breakpoint stop.
REQ-016 CMD_ERR  out  1  one-cycle pulse on a dropped command.
REQ-017 RETIRED  out  16  count of retired instructions.

Function
REQ-018 EN_L SHALL be decoded from the state register only: 0 in RUN/STEP, 1 in IDLE/HALT; never combinational from inputs.
REQ-019 CMD_READY SHALL be 1 in every state except during RESET.
REQ-020 IDLE: RUN -> RUN; STEP -> STEP with remaining = max(STEP_COUNT,1); STOP/NOP -> stay, no error.
REQ-021 RUN/STEP: RUN or STEP accepted -> dropped, CMD_ERR pulse; STOP -> IDLE at the next edge, DONE pulse.
REQ-022 Halt detect: in RUN/STEP, NextPC == PC SHALL move to HALT at the next edge; no DONE pulse.
REQ-023 HALT SHALL be exited only by RESET; any RUN/STEP/STOP accepted in HALT SHALL pulse CMD_ERR.
REQ-024 STEP SHALL hold EN_L low for exactly remaining cycles, decrementing per cycle; the cycle with remaining == 1 -> IDLE, DONE pulse.
REQ-025 Breakpoint: in RUN with BP_ARM = 1, NextPC == BP_ADDR -> IDLE at the next edge, BP_HIT set, DONE pulse; the instruction at BP_ADDR SHALL NOT execute.
REQ-026 Breakpoint SHALL NOT apply in STEP.
REQ-027 Same-cycle priority: halt detect > STOP > breakpoint > step-count expiry.
REQ-028 BP_HIT SHALL clear on accepted RUN or STEP.
REQ-029 RETIRED SHALL increment when EN_L = 0 and NextPC != PC; saturate at 16'hFFFF.
REQ-030 PC wrap-around (8'hFF to 8'h00) SHALL be treated as a normal retire.

Reset
REQ-031 RESET SHALL force, at the next edge and regardless of state or command: STATE = IDLE, EN_L = 1, DONE = 0, BP_HIT = 0, CMD_ERR = 0, RETIRED = 0, remaining = 0.
REQ-032 RESET mid-RUN/STEP SHALL abort with no DONE pulse.

Configuration
REQ-033 Macro RUN_CTRL_BREAKPOINT_EN:
- Defined: REQ-025/026/028 breakpoint logic is compiled in.
- Undefined: BP_ADDR and BP_ARM remain as ports but are ignored; BP_HIT is tied 0.

Structure
REQ-034 Package run_ctrl_pkg SHALL hold the state encoding constants, the command encoding constants, and the RETIRED width.
REQ-035 Saturating counter SHALL be a sub-module, retire_counter.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Reset, then STEP with STEP_COUNT = 3 and PC advancing by 2 -> EN_L low for exactly 3 cycles, DONE pulse, RETIRED = 3, STATE = IDLE.
- STEP_COUNT = 0 -> exactly 1 cycle with EN_L low.
- RUN, BP_ARM = 1, BP_ADDR = 8'h08, PC sequence 0,2,4,6 -> stop with PC = 8'h08, EN_L = 1, BP_HIT = 1, RETIRED = 4.
- RUN, then NextPC == PC at PC = 8'h0A -> STATE = HALT; subsequent RUN -> CMD_ERR pulse, still HALT; RESET -> IDLE.
- RUN, then STOP and halt detect in the same cycle -> HALT, no DONE pulse.
- RUN with RETIRED preloaded to near saturation -> holds 16'hFFFF.
- RESET asserted during STEP with remaining = 5 -> IDLE, RETIRED = 0, no DONE pulse.
